// File: rtl/bsg_link_sdr_rx_checker.sv
// Receive-side checker for an SDR link test pattern: every accepted word must carry
// (seq + c) in channel c; the first mismatch is captured and the checker parks in FAIL.
module bsg_link_sdr_rx_checker #(
  parameter int num_channels_p  = 8,
  parameter int channel_width_p = 8,
  parameter int stall_period_p  = 0,
  parameter int count_width_p   = 32
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      en_i,
  input  logic                                      clear_i,
  input  logic                                      v_i,
  input  logic [num_channels_p*channel_width_p-1:0] data_i,
  output logic                                      ready_o,
  output logic                                      error_o,
  output logic [count_width_p-1:0]                  received_o,
  output logic [num_channels_p*channel_width_p-1:0] err_data_o,
  output logic [num_channels_p*channel_width_p-1:0] err_expected_o
);

  localparam int data_width_lp  = num_channels_p * channel_width_p;
  localparam bit stall_en_lp    = (stall_period_p > 0);
  localparam int stall_width_lp = (stall_period_p > 1) ? $clog2(stall_period_p) : 1;
  localparam logic [stall_width_lp-1:0] stall_last_lp =
    stall_en_lp ? stall_width_lp'(stall_period_p - 1) : '0;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    RUN_S  = 2'd1,
    FAIL_S = 2'd2
  } state_e;

  state_e                     state_r;
  logic [channel_width_p-1:0] seq_r;
  logic [stall_width_lp-1:0]  stall_cnt_r;
  logic [count_width_p-1:0]   received_r;
  logic                       error_r;
  logic [data_width_lp-1:0]   err_data_r;
  logic [data_width_lp-1:0]   err_expected_r;

  logic                       stall_s;
  logic                       ready_s;
  logic                       accept_s;
  logic                       match_s;
  logic [data_width_lp-1:0]   expected_s;

  // Channel c of the expected word is seq + c, wrapping within the channel width.
  function automatic logic [data_width_lp-1:0] expected_word(input logic [channel_width_p-1:0] seq);
    logic [data_width_lp-1:0] word;
    word = '0;
    for (int c = 0; c < num_channels_p; c++) begin
      word[c*channel_width_p +: channel_width_p] = seq + channel_width_p'(c);
    end
    return word;
  endfunction

  // Ready decode from registered state only, so no path exists from v_i or data_i.
  always_comb begin
    stall_s = 1'b0;
    ready_s = 1'b0;
    case (state_r)
      RUN_S: begin
        if (stall_en_lp && (stall_cnt_r == stall_last_lp)) begin
          stall_s = 1'b1;
        end else begin
          stall_s = 1'b0;
        end
        ready_s = ~stall_s;
      end
      FAIL_S:  ready_s = 1'b1;
      IDLE_S:  ready_s = 1'b0;
      default: ready_s = 1'b0;
    endcase
  end

  // Acceptance and comparison against the current sequence value.
  always_comb begin
    accept_s   = v_i & ready_s;
    expected_s = expected_word(seq_r);
    match_s    = (data_i == expected_s);
  end

  // Main state machine, sequence tracking, counters and first-error capture.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r        <= IDLE_S;
      seq_r          <= '0;
      stall_cnt_r    <= '0;
      received_r     <= '0;
      error_r        <= 1'b0;
      err_data_r     <= '0;
      err_expected_r <= '0;
    end else if (clear_i) begin
      // Clear wins over everything, including a word accepted this cycle.
      state_r        <= IDLE_S;
      seq_r          <= '0;
      stall_cnt_r    <= '0;
      received_r     <= '0;
      error_r        <= 1'b0;
      err_data_r     <= '0;
      err_expected_r <= '0;
    end else begin
      case (state_r)
        IDLE_S: begin
          if (en_i) begin
            state_r <= RUN_S;
          end else begin
            state_r <= IDLE_S;
          end
        end
        RUN_S: begin
          if (stall_en_lp) begin
            if (stall_cnt_r == stall_last_lp) begin
              stall_cnt_r <= '0;
            end else begin
              stall_cnt_r <= stall_cnt_r + stall_width_lp'(1'b1);
            end
          end else begin
            stall_cnt_r <= '0;
          end
          // A mismatch takes precedence over leaving RUN through en_i.
          if (accept_s && !match_s) begin
            error_r        <= 1'b1;
            err_data_r     <= data_i;
            err_expected_r <= expected_s;
            state_r        <= FAIL_S;
          end else begin
            if (accept_s) begin
              received_r <= received_r + count_width_p'(1'b1);
              seq_r      <= seq_r + channel_width_p'(1'b1);
            end else begin
              received_r <= received_r;
              seq_r      <= seq_r;
            end
            if (en_i) begin
              state_r <= RUN_S;
            end else begin
              state_r <= IDLE_S;
            end
          end
        end
        FAIL_S: begin
          state_r <= FAIL_S;
        end
        default: begin
          state_r <= IDLE_S;
        end
      endcase
    end
  end

  assign ready_o        = ready_s;
  assign error_o        = error_r;
  assign received_o     = received_r;
  assign err_data_o     = err_data_r;
  assign err_expected_o = err_expected_r;

endmodule

// File: tb/tb_bsg_link_sdr_rx_checker.sv
// Randomized bench for bsg_link_sdr_rx_checker: one DUT without backpressure and one
// with stall_period_p=4, both compared against a behavioural model of the pattern rules.
module tb_bsg_link_sdr_rx_checker;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        en_i;
  logic        clear_i;
  logic        v_i;
  logic [63:0] data_i;

  logic        ready_w [2];
  logic        error_w [2];
  logic [31:0] recv_w  [2];
  logic [63:0] ed_w    [2];
  logic [63:0] ee_w    [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 = idle, 1 = running, 2 = failed.
  int          m_mode [2];
  int unsigned m_seq  [2];
  int unsigned m_recv [2];
  bit          m_err  [2];
  logic [63:0] m_ed   [2];
  logic [63:0] m_ee   [2];
  int unsigned m_runs [2];
  int          m_per  [2] = '{0, 4};

  bsg_link_sdr_rx_checker dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .clear_i(clear_i), .v_i(v_i),
    .data_i(data_i), .ready_o(ready_w[0]), .error_o(error_w[0]), .received_o(recv_w[0]),
    .err_data_o(ed_w[0]), .err_expected_o(ee_w[0])
  );

  bsg_link_sdr_rx_checker #(.stall_period_p(4)) dut_stall (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .clear_i(clear_i), .v_i(v_i),
    .data_i(data_i), .ready_o(ready_w[1]), .error_o(error_w[1]), .received_o(recv_w[1]),
    .err_data_o(ed_w[1]), .err_expected_o(ee_w[1])
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] exp_word(input int unsigned s);
    logic [63:0] w;
    for (int c = 0; c < 8; c++) w[c*8 +: 8] = 8'((s + c) % 256);
    return w;
  endfunction

  function automatic bit m_ready(input int k);
    if (m_mode[k] == 1) begin
      if (m_per[k] == 0) return 1'b1;
      return (m_runs[k] % m_per[k]) != (m_per[k] - 1);
    end
    return m_mode[k] == 2;
  endfunction

  task automatic model_reset(input int k);
    m_mode[k] = 0; m_seq[k] = 0; m_recv[k] = 0; m_err[k] = 1'b0;
    m_ed[k] = '0; m_ee[k] = '0; m_runs[k] = 0;
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic step(input bit en, input bit clr, input bit v, input logic [63:0] d);
    bit acc [2];
    en_i = en; clear_i = clr; v_i = v; data_i = d;
    for (int k = 0; k < 2; k++) acc[k] = v && m_ready(k);
    @(posedge clk_i);
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        model_reset(k);
      end else if (m_mode[k] == 1) begin
        if (acc[k]) begin
          if (d === exp_word(m_seq[k])) begin
            m_recv[k] = m_recv[k] + 1;
            m_seq[k]  = (m_seq[k] + 1) % 256;
          end else begin
            m_err[k] = 1'b1; m_ed[k] = d; m_ee[k] = exp_word(m_seq[k]); m_mode[k] = 2;
          end
        end
        m_runs[k] = m_runs[k] + 1;
        if (m_mode[k] == 1 && !en) m_mode[k] = 0;
      end else if (m_mode[k] == 0) begin
        if (en) m_mode[k] = 1;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    reset_i = 1'b1; en_i = 1'b0; clear_i = 1'b0; v_i = 1'b0; data_i = '0;
    model_reset(0); model_reset(1);
    @(negedge clk_i);
    n_checks++; if (ready_w[0] !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready_w[0]); end
    n_checks++; if (error_w[0] !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error_w[0]); end
    n_checks++; if (recv_w[0] !== 32'd0) begin n_fail++; $display("FAIL reset_received: got %0d expected 0", recv_w[0]); end
    n_checks++; if (ed_w[0] !== 64'd0) begin n_fail++; $display("FAIL reset_err_data: got %h expected 0", ed_w[0]); end
    n_checks++; if (ee_w[0] !== 64'd0) begin n_fail++; $display("FAIL reset_err_expected: got %h expected 0", ee_w[0]); end
    n_checks++; if (ready_w[1] !== 1'b0) begin n_fail++; $display("FAIL reset_ready_stall: got %b expected 0", ready_w[1]); end
    reset_i = 1'b0;
    step(1'b1, 1'b0, 1'b1, 64'h0706050403020100);
    n_checks++; if (recv_w[0] !== 32'd0) begin n_fail++; $display("FAIL first_edge_no_accept: got %0d expected 0", recv_w[0]); end
    n_checks++; if (ready_w[0] !== 1'b1) begin n_fail++; $display("FAIL run_ready: got %b expected 1", ready_w[0]); end
    step(1'b1, 1'b0, 1'b1, 64'h0706050403020100);
    n_checks++; if (recv_w[0] !== 32'd1) begin n_fail++; $display("FAIL second_edge_accept: got %0d expected 1", recv_w[0]); end
  endtask

  task automatic test_basic();
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 64'h0706050403020100);
    step(1'b1, 1'b0, 1'b1, 64'h0706050403020100);
    step(1'b1, 1'b0, 1'b1, 64'h0807060504030201);
    n_checks++; if (recv_w[0] !== 32'd2) begin n_fail++; $display("FAIL basic_received: got %0d expected 2", recv_w[0]); end
    n_checks++; if (error_w[0] !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b expected 0", error_w[0]); end
  endtask

  task automatic test_mismatch();
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 64'h0706050403020100);
    step(1'b1, 1'b0, 1'b1, 64'h0807060504030200);
    n_checks++; if (error_w[0] !== 1'b1) begin n_fail++; $display("FAIL mm_error: got %b expected 1", error_w[0]); end
    n_checks++; if (ed_w[0] !== 64'h0807060504030200) begin n_fail++; $display("FAIL mm_err_data: got %h expected 0807060504030200", ed_w[0]); end
    n_checks++; if (ee_w[0] !== 64'h0807060504030201) begin n_fail++; $display("FAIL mm_err_expected: got %h expected 0807060504030201", ee_w[0]); end
    n_checks++; if (recv_w[0] !== 32'd1) begin n_fail++; $display("FAIL mm_received: got %0d expected 1", recv_w[0]); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (ready_w[0] !== 1'b1) begin n_fail++; $display("FAIL fail_ready: got %b expected 1", ready_w[0]); end
      step(1'($urandom_range(0, 1)), 1'b0, 1'b1, (i == 0) ? 64'h0807060504030201 : {$urandom, $urandom});
    end
    n_checks++; if (recv_w[0] !== 32'd1) begin n_fail++; $display("FAIL fail_frozen_received: got %0d expected 1", recv_w[0]); end
    n_checks++; if (ed_w[0] !== 64'h0807060504030200) begin n_fail++; $display("FAIL fail_frozen_err_data: got %h expected 0807060504030200", ed_w[0]); end
  endtask

  task automatic test_stall();
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (ready_w[1] !== ((i % 4) != 3)) begin
        n_fail++; $display("FAIL stall_ready cycle %0d: got %b expected %b", i, ready_w[1], (i % 4) != 3);
      end
      step(1'b1, 1'b0, 1'b1, exp_word(m_seq[1]));
    end
    n_checks++; if (recv_w[1] !== 32'd12) begin n_fail++; $display("FAIL stall_received: got %0d expected 12", recv_w[1]); end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b1, (i == 256) ? 64'h0706050403020100 :
                              (i == 255) ? 64'h06050403020100ff : exp_word(m_seq[0]));
    end
    n_checks++; if (recv_w[0] !== 32'd300) begin n_fail++; $display("FAIL wrap_received: got %0d expected 300", recv_w[0]); end
    n_checks++; if (error_w[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_error: got %b expected 0", error_w[0]); end
  endtask

  task automatic test_clear_in_fail();
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 64'h0706050403020100);
    step(1'b1, 1'b0, 1'b1, 64'h1111111111111111);
    n_checks++; if (error_w[0] !== 1'b1) begin n_fail++; $display("FAIL clr_pre_error: got %b expected 1", error_w[0]); end
    step(1'b1, 1'b1, 1'b1, 64'hdeadbeefdeadbeef);
    n_checks++; if (error_w[0] !== 1'b0) begin n_fail++; $display("FAIL clr_error: got %b expected 0", error_w[0]); end
    n_checks++; if (recv_w[0] !== 32'd0) begin n_fail++; $display("FAIL clr_received: got %0d expected 0", recv_w[0]); end
    n_checks++; if (ready_w[0] !== 1'b0) begin n_fail++; $display("FAIL clr_idle_ready: got %b expected 0", ready_w[0]); end
    n_checks++; if (ed_w[0] !== 64'd0) begin n_fail++; $display("FAIL clr_err_data: got %h expected 0", ed_w[0]); end
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 64'h0706050403020100);
    for (int i = 1; i < 5; i++) step(1'b1, 1'b0, 1'b1, exp_word(i));
    n_checks++; if (recv_w[0] !== 32'd5) begin n_fail++; $display("FAIL clr_restream_received: got %0d expected 5", recv_w[0]); end
    n_checks++; if (error_w[0] !== 1'b0) begin n_fail++; $display("FAIL clr_restream_error: got %b expected 0", error_w[0]); end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, exp_word(i));
    en_i = 1'b1; v_i = 1'b1; data_i = exp_word(5);
    #2 reset_i = 1'b1;
    model_reset(0); model_reset(1);
    #1;
    n_checks++; if (ready_w[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 0", ready_w[0]); end
    n_checks++; if (recv_w[0] !== 32'd0) begin n_fail++; $display("FAIL rst_mid_received: got %0d expected 0", recv_w[0]); end
    n_checks++; if (ready_w[1] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready_stall: got %b expected 0", ready_w[1]); end
    @(negedge clk_i);
    n_checks++; if (recv_w[0] !== 32'd0) begin n_fail++; $display("FAIL rst_hold_received: got %0d expected 0", recv_w[0]); end
    reset_i = 1'b0;
    step(1'b1, 1'b0, 1'b1, 64'h0706050403020100);
    step(1'b1, 1'b0, 1'b1, 64'h0706050403020100);
    step(1'b1, 1'b0, 1'b1, 64'h0807060504030201);
    step(1'b1, 1'b0, 1'b1, 64'h0908070605040302);
    n_checks++; if (recv_w[0] !== 32'd3) begin n_fail++; $display("FAIL rst_restream_received: got %0d expected 3", recv_w[0]); end
    n_checks++; if (error_w[0] !== 1'b0) begin n_fail++; $display("FAIL rst_restream_error: got %b expected 0", error_w[0]); end
  endtask

  task automatic test_random();
    bit          en, clr, v;
    int          kp;
    logic [63:0] d;
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ready_w[k] !== m_ready(k)) begin
          n_fail++; $display("FAIL rand_ready dut%0d cycle %0d: got %b expected %b", k, i, ready_w[k], m_ready(k));
        end
      end
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 29) == 0);
      v   = ($urandom_range(0, 3) != 0);
      kp  = int'($urandom_range(0, 1));
      d   = ($urandom_range(0, 24) == 0) ? {$urandom, $urandom} : exp_word(m_seq[kp]);
      step(en, clr, v, d);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (error_w[k] !== m_err[k] || recv_w[k] !== m_recv[k] || ed_w[k] !== m_ed[k] || ee_w[k] !== m_ee[k]) begin
          n_fail++;
          $display("FAIL rand_state dut%0d cycle %0d: got err=%b recv=%0d ed=%h ee=%h expected err=%b recv=%0d ed=%h ee=%h",
                   k, i, error_w[k], recv_w[k], ed_w[k], ee_w[k], m_err[k], m_recv[k], m_ed[k], m_ee[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_stall();
    test_wrap();
    test_clear_in_fail();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_link_sdr_rx_checker.md
BSG_LINK_SDR_RX_CHECKER -- requirements
Module: bsg_link_sdr_rx_checker

Interface
REQ-001 The module SHALL have parameter num_channels_p, default 8, giving the number of channels packed in one data word.
REQ-002 The module SHALL have parameter channel_width_p, default 8, giving the bit width of each channel.
REQ-003 The module SHALL have parameter stall_period_p, default 0, where 0 means no backpressure and N>0 means ready_o drops for one cycle in every N.
REQ-004 The module SHALL have parameter count_width_p, default 32, giving the width of received_o.
REQ-005 The module SHALL have port clk_i, input, 1 bit: the single clock. One clock; reset is asynchronous and active-high.
REQ-006 The module SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 The module SHALL have port en_i, input, 1 bit: enables reception.
REQ-008 The module SHALL have port clear_i, input, 1 bit: synchronous restart.
REQ-009 The module SHALL have port v_i, input, 1 bit: link word valid.
REQ-010 The module SHALL have port data_i, input, num_channels_p*channel_width_p bits: link word; channel c occupies bits [c*channel_width_p +: channel_width_p].
REQ-011 The module SHALL have port ready_o, output, 1 bit: checker can accept a word.
REQ-012 The module SHALL have port error_o, output, 1 bit: sticky mismatch flag.
REQ-013 The module SHALL have port received_o, output, count_width_p bits: number of correct words accepted.
REQ-014 The module SHALL have port err_data_o, output, data width: the first mismatching word received.
REQ-015 The module SHALL have port err_expected_o, output, data width: the word expected at the first mismatch.

Function
REQ-016 A word SHALL be accepted exactly on cycles where v_i & ready_o; the upstream yumi is formed outside the module as v_i & ready_o.
REQ-017 ready_o SHALL be a function of registered state only, with no combinational path from v_i or data_i.
REQ-018 The expected word SHALL be, in channel c, (seq_r + c) mod 2^channel_width_p, where seq_r is an internal channel_width_p-bit sequence register.
REQ-019 The state machine SHALL have three states: IDLE, RUN and FAIL.
REQ-020 In IDLE: ready_o=0; the module SHALL move to RUN on the next edge when en_i=1.
REQ-021 In RUN: ready_o=1 except on stall cycles.
REQ-022 In RUN: the module SHALL move to IDLE on the next edge when en_i=0; a word accepted in that same cycle SHALL still be checked.
REQ-023 Stall counter: it SHALL count cycles spent in RUN from 0 to stall_period_p-1 and then wrap; ready_o=0 when the counter equals stall_period_p-1. When stall_period_p=0 the counter is unused and the module never stalls.
REQ-024 An accepted word equal to the expected word SHALL, on the next edge, increment received_o (wrapping at 2^count_width_p) and increment seq_r (wrapping at 2^channel_width_p).
REQ-025 An accepted word not equal to the expected word SHALL, on the next edge, set error_o=1, load err_data_o with data_i and err_expected_o with the expected word, and move to FAIL.
REQ-026 On a mismatch, received_o and seq_r SHALL remain unchanged.
REQ-027 In FAIL: ready_o=1 so the link drains; accepted words SHALL be discarded, and received_o, seq_r and the err_* outputs SHALL be frozen. en_i is ignored in FAIL.
REQ-028 FAIL SHALL be left only through clear_i or reset_i.
REQ-029 clear_i=1 SHALL take priority over every other event and, on the next edge, return the module to IDLE and zero seq_r, the stall counter, received_o, error_o, err_data_o and err_expected_o.
REQ-030 A word accepted in a cycle where clear_i=1 SHALL be discarded and not checked.
REQ-031 Outputs other than ready_o SHALL be driven directly from registers.

Reset
REQ-032 While reset_i=1 the module SHALL be in IDLE with seq_r=0, stall counter=0, ready_o=0, error_o=0, received_o=0, err_data_o=0 and err_expected_o=0, asynchronously and independent of clk_i.
REQ-033 Assertion of reset_i in the middle of a transfer SHALL drop ready_o immediately; the in-flight word SHALL be neither counted nor checked.
REQ-034 After deassertion of reset_i, the first acceptance SHALL be possible no earlier than the second clk_i edge, since en_i must first move the module from IDLE to RUN.

Verification
REQ-035 Defaults; en_i=1; drive 0x0706050403020100, then 0x0807060504030201, with v_i held high -> the module accepts one word per cycle, received_o=2, error_o=0.
REQ-036 Send 0x0706050403020100, then 0x0807060504030200 -> error_o=1, err_data_o=0x0807060504030200, err_expected_o=0x0807060504030201, received_o=1, ready_o=1 in FAIL; a further 10 words leave received_o at 1.
REQ-037 stall_period_p=4; v_i held high for 16 cycles in RUN -> ready_o low on RUN cycles 3, 7, 11 and 15 (0-based), giving 12 accepted words and received_o=12.
REQ-038 Stream 300 correct words -> seq_r wraps after 0xFF; word 256 expected = 0x0706050403020100, received_o=300, error_o=0.
REQ-039 Raise clear_i in FAIL on the same cycle as v_i=1 carrying a wrong word -> next cycle IDLE, error_o=0, received_o=0; the word is not checked; the following correct stream starting at 0x0706050403020100 passes.
REQ-040 Assert reset_i mid-stream, between clock edges -> ready_o=0 and received_o=0 immediately; after release and en_i=1 the stream restarting at seq 0 passes.
